// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Consumed by pc_sequencer and pc_next_adder.
package pc_seq_pkg;

    localparam int PC_ADDR_W = 11;
    localparam logic [PC_ADDR_W-1:0] PC_RESET_VAL = '0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECIDE = 3'd2,
        ST_HALT   = 3'd3,
        ST_TRAP   = 3'd4
    } pc_state_e;

endpackage

// File: rtl/pc_next_adder.sv
// Combinational next-PC adder returning {carry, sum}.
// The carry is kept so the wrap detector can use it.
module pc_next_adder
    import pc_seq_pkg::*;
#(
    parameter int W = PC_ADDR_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake plus increment/branch/jump next-PC.
// Optional macro PC_WRAP_TRAP_EN turns an address wrap into a sticky trap.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | imem_req high at pc, waiting for imem_ack
// DECIDE | instruction available, pc updated by priority select
// HALT   | pc held, start resumes fetching
// TRAP   | pc wrapped with trapping enabled; only reset exits
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = PC_RESET_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              instr_fetched,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              trap
);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_addend;
    logic [ADDR_W:0]   w_sum;
    logic              w_use_branch;

    assign w_use_branch = !halt_req && !jump_valid && branch_valid;
    assign w_addend     = w_use_branch ? branch_offset : ADDR_W'(1);

    pc_next_adder #(.W(ADDR_W)) u_adder (
        .i_a   (r_pc),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

`ifdef PC_WRAP_TRAP_EN
    // Positive addend wraps on carry; negative addend wraps when no carry appears.
    logic w_wrap;
    assign w_wrap = w_addend[ADDR_W-1] ? !w_sum[ADDR_W] : w_sum[ADDR_W];
`else
    logic w_unused_carry;
    assign w_unused_carry = w_sum[ADDR_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (imem_ack) w_state_nxt = ST_DECIDE;
            ST_DECIDE: begin
                if (!halt_req && jump_valid) begin
                    w_pc_nxt    = jump_target;
                    w_state_nxt = ST_FETCH;
                end else begin
`ifdef PC_WRAP_TRAP_EN
                    if (w_wrap) begin
                        w_state_nxt = ST_TRAP;
                    end else
`endif
                    begin
                        w_pc_nxt    = w_sum[ADDR_W-1:0];
                        w_state_nxt = halt_req ? ST_HALT : ST_FETCH;
                    end
                end
            end
            ST_HALT:  if (start) w_state_nxt = ST_FETCH;
            ST_TRAP:  w_state_nxt = ST_TRAP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req      = (r_state == ST_FETCH);
        instr_fetched = (r_state == ST_DECIDE);
        busy          = (r_state == ST_FETCH) || (r_state == ST_DECIDE);
`ifdef PC_WRAP_TRAP_EN
        trap          = (r_state == ST_TRAP);
`else
        trap          = 1'b0;
`endif
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Honours PC_WRAP_TRAP_EN for the wrap expectations.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        jump_valid;
    logic [10:0] jump_target;
    logic        branch_valid;
    logic [10:0] branch_offset;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ack;
    logic        instr_fetched;
    logic [10:0] pc;
    logic        busy;
    logic        trap;

    int n_total = 0;
    int n_bad   = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt_req      (halt_req),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_valid  (branch_valid),
        .branch_offset (branch_offset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_fetched (instr_fetched),
        .pc            (pc),
        .busy          (busy),
        .trap          (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: ack, then in DECIDE apply a jump, landing in FETCH at tgt.
    task automatic jump_to(input logic [10:0] tgt);
        imem_ack = 1'b1;
        step();
        imem_ack    = 1'b0;
        jump_valid  = 1'b1;
        jump_target = tgt;
        step();
        jump_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; jump_valid = 1'b0;
        jump_target = '0; branch_valid = 1'b0; branch_offset = '0; imem_ack = 1'b0;
        #12;
        check("rst_req",   imem_req,      0);
        check("rst_addr",  imem_addr,     0);
        check("rst_pc",    pc,            0);
        check("rst_busy",  busy,          0);
        check("rst_fetch", instr_fetched, 0);
        check("rst_trap",  trap,          0);
        rst_n = 1'b1;
        step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("idle_ignores_ack", imem_req, 0);

        start = 1'b1;
        step();
        start = 1'b0;

        // Sequential fetches with ack one cycle after each request.
        for (int i = 0; i < 10; i++) begin
            check("seq_addr",  imem_addr, i);
            check("seq_req",   imem_req,  1);
            check("seq_busy",  busy,      1);
            check("seq_nofet", instr_fetched, 0);
            imem_ack = 1'b1;
            step();
            imem_ack = 1'b0;
            check("seq_fetched", instr_fetched, 1);
            check("seq_busy_d",  busy,          1);
            check("seq_noreq",   imem_req,      0);
            step();
        end
        check("at_pc10", pc, 10);

        // Branch -3 from 10.
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        branch_valid = 1'b1; branch_offset = 11'h7FD;
        step();
        branch_valid = 1'b0;
        check("branch_back", imem_addr, 7);

        // Jump beats branch.
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        branch_valid = 1'b1; branch_offset = 11'h7FD;
        jump_valid = 1'b1; jump_target = 11'd400;
        step();
        branch_valid = 1'b0; jump_valid = 1'b0;
        check("jump_wins", imem_addr, 400);

        // Ack withheld for 5 cycles; DECIDE-only inputs must be ignored.
        halt_req = 1'b1; jump_valid = 1'b1; jump_target = 11'd55; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_addr", imem_addr, 400);
            check("stall_req",  imem_req,  1);
            check("stall_pc",   pc,        400);
        end
        halt_req = 1'b0; jump_valid = 1'b0; start = 1'b0;

        // Halt at 20.
        jump_to(11'd20);
        check("at_pc20", imem_addr, 20);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_pc",   pc,       21);
        check("halt_req",  imem_req, 0);
        check("halt_busy", busy,     0);
        step();
        step();
        check("halt_hold", pc, 21);
        start = 1'b1;
        step();
        start = 1'b0;
        check("resume_addr", imem_addr, 21);
        check("resume_req",  imem_req,  1);

        // Modulo branch: 21 + (-2) = 19.
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        branch_valid = 1'b1; branch_offset = 11'h7FE;
        step();
        branch_valid = 1'b0;
        check("branch_m2", imem_addr, 19);

        // Increment from 2047.
        jump_to(11'd2047);
        check("at_2047", imem_addr, 2047);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
`ifdef PC_WRAP_TRAP_EN
        check("wrap_trap",    trap,     1);
        check("wrap_pc",      pc,       2047);
        check("wrap_req",     imem_req, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("trap_sticky",  trap,     1);
        check("trap_pc_hold", pc,       2047);
        check("trap_nostart", imem_req, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
`else
        check("wrap_addr", imem_addr, 0);
        check("wrap_req",  imem_req,  1);
        check("wrap_trap", trap,      0);
`endif

        // Asynchronous reset mid-FETCH at 300.
        jump_to(11'd300);
        check("at_300",  imem_addr, 300);
        check("req_300", imem_req,  1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",  imem_req,  0);
        check("arst_pc",   pc,        0);
        check("arst_addr", imem_addr, 0);
        check("arst_busy", busy,      0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_idle", imem_req, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 11-bit CPU datapath. Holds the PC, runs an instruction-fetch handshake with instruction memory, and computes the next PC each instruction: increment, signed relative branch or absolute jump. Its next-PC arithmetic is an 11-bit add on the same operand format as the CPU's eleven-bit adder, and it feeds the fetched address stream to decode.

## Interface
- `ADDR_W`, 11: PC/address width. The design is verified at 11 only.
- `RESET_PC`, 11'd0: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; leaves IDLE/HALT and begins fetching.
- `halt_req`  in  1  sampled in DECIDE; stop after the current instruction.
- `jump_valid`  in  1  sampled in DECIDE; absolute jump.
- `jump_target`  in  ADDR_W  absolute target.
- `branch_valid`  in  1  sampled in DECIDE; relative branch taken.
- `branch_offset`  in  ADDR_W  two's-complement offset added to the PC.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  ADDR_W  fetch address, equal to `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory accepted and returned the word this cycle.
- `instr_fetched`  out  1  one-cycle pulse in DECIDE: instruction at `pc` is available.
- `pc`  out  ADDR_W  current PC.
- `busy`  out  1  high in FETCH and DECIDE.
- `trap`  out  1  PC wrap trap. Only present in behaviour when `PC_WRAP_TRAP_EN` is defined; tied 0 otherwise.

## Operation
- FSM states: IDLE, FETCH, DECIDE, HALT, TRAP.
- IDLE: `start` → FETCH. All other inputs are ignored.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`=1 → DECIDE. Otherwise stay, with address and request stable.
- DECIDE: `instr_fetched`=1. `pc` is loaded from a fixed-priority selection:
  - `halt_req`: pc+1, then → HALT.
  - `jump_valid`: `jump_target`, then → FETCH.
  - `branch_valid`: pc+`branch_offset`, then → FETCH.
  - Otherwise: pc+1, then → FETCH.
- HALT: `pc` is held. `start` → FETCH and fetch resumes at the held `pc`.
- TRAP: `pc` is held and `trap`=1. The only exit is reset.
- Arithmetic is modulo 2^11; the carry out is discarded unless trapping is enabled.
  - 2047+1 = 0.
  - 5 + 11'h7FE (−2) = 3.
- `start` is ignored in FETCH, DECIDE and TRAP.
- `imem_ack` is ignored outside FETCH.
- `jump_valid`, `branch_valid` and `halt_req` are ignored outside DECIDE.

## Timing
- Reset (asynchronous, effective immediately regardless of state):
  - state=IDLE, `pc`=RESET_PC.
  - `imem_req`=0, `imem_addr`=RESET_PC, `instr_fetched`=0, `busy`=0, `trap`=0.
- `start` in cycle t → `imem_req`=1 in cycle t+1.
- `imem_ack` in cycle n → `instr_fetched`=1 in cycle n+1 → new `pc` and `imem_req`=1 in cycle n+2.
- Best-case throughput is one instruction per 2 cycles (ack in the first FETCH cycle).
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Reset asserted during FETCH drops `imem_req` in the same cycle. The memory must tolerate an abandoned request.

## Configuration
- Macro: `PC_WRAP_TRAP_EN`.
- Defined: in DECIDE, if the selected increment or branch leaves the range 0..2047, `pc` is not updated and the FSM → TRAP with `trap`=1 from the next cycle.
  - Increment case: the carry out of 2047+1.
  - Branch case: a positive offset produces a carry out, or a negative offset produces no carry out (signed crossing).
  - Jumps never trap.
  - `halt_req` wrap takes TRAP over HALT.
- Undefined: silent modulo wrap; `trap` is constant 0.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_state_e`.
  - `PC_ADDR_W`=11.
  - default `PC_RESET_VAL`.
- Sub-module `pc_next_adder`: combinational 11-bit adder returning {carry, sum} of `pc` and the selected addend (1 or `branch_offset`). This lets the wrap-detect logic reuse the carry.
- All remaining logic (FSM, PC register, priority mux) lives in `pc_sequencer`.

## Test plan
- Reset then `start`, with `imem_ack` returned one cycle after each request → addresses 0,1,2,3 with `instr_fetched` every 2nd cycle; `busy`=1 throughout.
- `pc`=10, `branch_valid`=1, `branch_offset`=11'h7FD (−3) → next `imem_addr`=7. Same cycle with `jump_valid`=1, target 400 → `imem_addr`=400 (jump wins).
- `imem_ack` withheld 5 cycles in FETCH → `imem_addr` and `imem_req` stable for all 5 cycles; `pc` unchanged.
- `halt_req` at `pc`=20 → HALT with `pc`=21 and `imem_req`=0. Later `start` → fetch at 21.
- `pc`=2047, increment:
  - Without the macro → `imem_addr`=0.
  - With `PC_WRAP_TRAP_EN` → `trap`=1, `pc`=2047, and `start` has no effect.
- `rst_n` dropped mid-FETCH at `pc`=300 → same-cycle `imem_req`=0, `pc`=RESET_PC, state IDLE.
